// File: rtl/multdiv_ctrl_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface multdiv_ctrl_if;
   logic [4:0] OP;
   logic [4:0] ALUOP;
   logic       valid_in;
   logic [4:0] dest_in;
   logic       divisor_zero;
   logic       cancel;
   logic       ctrl_MULT;
   logic       ctrl_DIV;
   logic       step;
   logic       stall;
   logic       result_rdy;
   logic       exception;
   logic [4:0] dest_out;
   logic       busy;

   modport master (
      output OP, ALUOP, valid_in, dest_in, divisor_zero, cancel,
      input  ctrl_MULT, ctrl_DIV, step, stall, result_rdy, exception, dest_out, busy
   );

   modport slave (
      input  OP, ALUOP, valid_in, dest_in, divisor_zero, cancel,
      output ctrl_MULT, ctrl_DIV, step, stall, result_rdy, exception, dest_out, busy
   );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit: decodes MUL/DIV, pulses start,
// counts iterations while stalling the front end, then issues a one-cycle result-ready.
module multdiv_ctrl #(
   parameter int CYCLES = 32
) (
   input  logic          clock,
   input  logic          resetn,
   multdiv_ctrl_if.slave bus
);
   localparam int CNTW = $clog2(CYCLES);
   localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CYCLES - 1);
   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [CNTW-1:0] cnt_r;
   logic            dz_r;
   logic            div_r;
   logic [4:0]      dest_r;

   logic            is_mul_s;
   logic            is_div_s;
   logic            start_s;
   logic            dz_now_s;
   logic            ctrl_mult_s;
   logic            ctrl_div_s;
   logic            step_s;
   logic            stall_s;
   logic            rdy_s;
   logic            exc_s;
   logic            busy_s;

   // Opcode decode, next-state selection and output decode.
   always_comb begin
      // resetn gates the decode so every output is low while reset is held
      is_mul_s = resetn & bus.valid_in & ~bus.cancel &
                 (bus.OP == 5'b00000) & (bus.ALUOP == 5'b00110);
      is_div_s = resetn & bus.valid_in & ~bus.cancel &
                 (bus.OP == 5'b00000) & (bus.ALUOP == 5'b00111);
      dz_now_s     = is_div_s & bus.divisor_zero;
      start_s      = 1'b0;
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (is_mul_s | is_div_s) begin
               start_s      = 1'b1;
               next_state_s = dz_now_s ? DONE : RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (bus.cancel) begin
               next_state_s = IDLE;
            end else if (cnt_r == CNT_ZERO) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase

      ctrl_mult_s = start_s & is_mul_s;
      ctrl_div_s  = start_s & is_div_s;
      step_s      = (state_r == RUN);
      stall_s     = start_s | step_s;
      rdy_s       = (state_r == DONE) & ~bus.cancel;
      exc_s       = rdy_s & dz_r & div_r;
      busy_s      = (state_r != IDLE);
   end

   // State, iteration counter and start-time operand latches.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         dz_r    <= 1'b0;
         div_r   <= 1'b0;
         dest_r  <= 5'b00000;
      end else begin
         state_r <= next_state_s;
         if (start_s) begin
            dest_r <= bus.dest_in;
            dz_r   <= dz_now_s;
            div_r  <= is_div_s;
            cnt_r  <= dz_now_s ? CNT_ZERO : CNT_LOAD;
         end else if ((state_r == RUN) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign bus.ctrl_MULT  = ctrl_mult_s;
   assign bus.ctrl_DIV   = ctrl_div_s;
   assign bus.step       = step_s;
   assign bus.stall      = stall_s;
   assign bus.result_rdy = rdy_s;
   assign bus.exception  = exc_s;
   assign bus.dest_out   = dest_r;
   assign bus.busy       = busy_s;
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the processor's iterative multiply/divide unit, located in the execute stage beside the ALU opcode decode. It decodes R-type MUL/DIV (OP = 00000, ALUOP = 00110 / 00111), pulses the unit's start control, and counts its iterations. It stalls the front of the pipeline for the whole operation, then issues a one-cycle result-ready, with an exception flag on divide-by-zero.

## Interface
- CYCLES, 32: iterations per MUL/DIV operation; legal values are 2 to 64.
- CNTW, $clog2(CYCLES): width of the iteration counter (derived).
- clock  in  1  sole clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- OP  in  5  opcode of the instruction in the execute stage.
- ALUOP  in  5  ALU opcode field of the same instruction.
- valid_in  in  1  the execute-stage instruction is valid.
- dest_in  in  5  rd field of the execute-stage instruction.
- divisor_zero  in  1  operand B equals 0; sampled only at start.
- cancel  in  1  flush from branch/jump resolution; aborts any operation in flight.
- ctrl_MULT  out  1  one-cycle start pulse to the multiplier.
- ctrl_DIV  out  1  one-cycle start pulse to the divider.
- step  out  1  iteration enable to the multdiv datapath.
- stall  out  1  freezes the PC and the F/D and D/X latches.
- result_rdy  out  1  one-cycle pulse: result is valid and may be written back.
- exception  out  1  qualifies result_rdy: divide-by-zero occurred (write rstatus).
- dest_out  out  5  rd latched at start; held stable until the next start.
- busy  out  1  state is not IDLE.

## Operation
- Decode (combinational):
  - is_mul = valid_in & OP==00000 & ALUOP==00110.
  - is_div = valid_in & OP==00000 & ALUOP==00111.
  - Both terms are qualified by ~cancel.
- States are IDLE, RUN and DONE.
- IDLE:
  - On is_mul or is_div: drive ctrl_MULT or ctrl_DIV high for this cycle and drive stall high combinationally in the same cycle.
  - Latch dest_out, the op kind, and dz = is_div & divisor_zero.
  - If dz, go to DONE. Otherwise load the counter with CYCLES-1 and go to RUN.
  - Any other instruction: stay in IDLE; all outputs stay low.
- RUN:
  - step=1 and stall=1.
  - Counter decrements each cycle. Leave for DONE on the cycle the counter equals 0.
- DONE:
  - result_rdy=1, exception=dz, stall=0.
  - The pipeline advances and writes back this cycle.
  - Next state is unconditionally IDLE.
  - A new MUL/DIV becomes visible in the execute stage in the following IDLE cycle, so back-to-back operations cost 1 idle-free turnaround cycle.
- cancel has the highest priority:
  - In RUN or DONE, go to IDLE next cycle. result_rdy and exception are forced low in the cycle cancel is high.
  - In IDLE, no start is issued.
- ctrl_MULT and ctrl_DIV are never high together. step is never high in IDLE or DONE.
- The counter never wraps. It only reloads in IDLE on a start.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE; counter = 0, dz = 0, dest_out = 00000.
  - All outputs are 0 (ctrl_MULT, ctrl_DIV, step, stall, result_rdy, exception, busy).
  - Reset mid-RUN aborts the operation with no result_rdy.
- Latency for a start at cycle T, without dz:
  - RUN occupies T+1 through T+CYCLES; DONE is at T+CYCLES+1.
  - stall is high for T through T+CYCLES (CYCLES+1 cycles).
  - result_rdy is high only at T+CYCLES+1.
- DIV with dz at cycle T:
  - DONE at T+1 with exception=1.
  - stall is high only at T; step never goes high.
- busy is high from T+1 through the DONE cycle inclusive.
- divisor_zero, dest_in, OP and ALUOP are ignored outside the IDLE start cycle.

## Test plan
- MUL, CYCLES=32, dest_in=00101 at cycle 10: ctrl_MULT high at 10 only; step high 11 through 42; stall high 10 through 42; result_rdy=1 at 43 with exception=0 and dest_out=00101.
- DIV with divisor_zero=1 at cycle 5: ctrl_DIV high at 5; stall high at 5 only; result_rdy=1 and exception=1 at 6; step never high.
- DIV, then a MUL presented at the cycle after DONE: second ctrl_MULT fires exactly 1 cycle after the first result_rdy; dest_out updates at that start.
- cancel=1 at the 10th RUN cycle of a MUL: IDLE next cycle; result_rdy never pulses; stall low from the cycle after cancel.
- resetn driven low asynchronously mid-RUN (between clock edges): all outputs are 0 immediately; after release, a non-multdiv instruction (ALUOP=00011) causes no start and no stall.
- Simultaneous cancel and valid MUL in IDLE: no ctrl_MULT, no stall, state stays IDLE.
